// File: rtl/fp_normalize_pipe_if.sv
// Handshake bundle for fp_normalize_pipe: input beat (valid/ready + operand) and output beat.
// slave is the normalizer's view; master is the upstream/downstream view.
interface fp_normalize_pipe_if #(
    parameter int EW = 5,
    parameter int FW = 10,
    parameter int MW = 24
);
    logic              i_valid;
    logic              i_ready;
    logic              i_sign;
    logic [EW-1:0]     i_exp;
    logic [MW-1:0]     i_man;
    logic              under_i;
    logic              o_valid;
    logic              o_ready;
    logic              o_sign;
    logic [EW-1:0]     o_exp;
    logic [FW+3:0]     o_sig;
    logic              under_o;
    logic              inexact_o;
    logic              overflow_o;

    modport slave (
        input  i_valid, i_sign, i_exp, i_man, under_i, o_ready,
        output i_ready, o_valid, o_sign, o_exp, o_sig, under_o, inexact_o, overflow_o
    );

    modport master (
        output i_valid, i_sign, i_exp, i_man, under_i, o_ready,
        input  i_ready, o_valid, o_sign, o_exp, o_sig, under_o, inexact_o, overflow_o
    );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Three-stage handshaked FP normalizer: increment/align, leading-zero count, shift.
// Define FP_NORM_DENORMALS_EN for gradual denormals; otherwise tiny results flush to zero.
module fp_normalize_pipe #(
    parameter int EW = 5,
    parameter int FW = 10,
    parameter int MW = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    fp_normalize_pipe_if.slave bus
);
    localparam int SW  = FW + 4;
    localparam int XW  = EW + 2;
    localparam int SHW = $clog2(SW + 1);
    localparam logic signed [XW-1:0] E_INF = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] E_ONE = XW'(1);

    // ---------------- handshake ----------------
    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3;

    assign w_ld3       = ce & (~r_v3 | bus.o_ready);
    assign w_ld2       = ce & (~r_v2 | w_ld3);
    assign w_ld1       = ce & (~r_v1 | w_ld2);
    assign bus.i_ready = w_ld1;
    assign bus.o_valid = r_v3;

    // ---------------- S1: increment and align ----------------
    logic                 w_inf;
    logic [1:0]           w_inc;
    logic signed [XW-1:0] w_exp_x;
    logic signed [XW-1:0] w_e1;
    logic [SW-1:0]        w_m1_opt [3];
    logic [SW-1:0]        w_m1;
    logic                 w_ovf;
    logic                 w_under;

    assign w_inf = (&bus.i_exp) & ~bus.under_i;

    always_comb begin
        w_inc = 2'd0;
        if (!w_inf) begin
            if (bus.i_man[MW-1])      w_inc = 2'd2;
            else if (bus.i_man[MW-2]) w_inc = 2'd1;
        end
    end

    // Underflowed exponents arrive as two's complement and must sign-extend.
    assign w_exp_x = bus.under_i ? {{2{bus.i_exp[EW-1]}}, bus.i_exp} : {2'b00, bus.i_exp};
    assign w_e1    = w_exp_x + $signed({{(XW-2){1'b0}}, w_inc});

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_align
            localparam int T = MW - 3 + gi;
            assign w_m1_opt[gi] = {bus.i_man[T -: FW+3], |bus.i_man[T-FW-3:0]};
        end
    endgenerate

    always_comb begin
        case (w_inc)
            2'd2:    w_m1 = w_m1_opt[2];
            2'd1:    w_m1 = w_m1_opt[1];
            default: w_m1 = w_m1_opt[0];
        endcase
    end

    assign w_ovf   = ~bus.under_i & ~w_inf & (w_e1 >= E_INF);
    assign w_under = bus.under_i & (w_e1 < E_ONE);

    logic                 r_s1_sign, r_s1_inf, r_s1_ovf, r_s1_under;
    logic signed [XW-1:0] r_s1_e1;
    logic [SW-1:0]        r_s1_m1;

    // ---------------- S2: leading-zero count and shift decision ----------------
    logic [SHW-1:0] w_lzc;

`ifdef FP_NORM_DENORMALS_EN
    always_comb begin
        w_lzc = SHW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (r_s1_m1[i]) w_lzc = SHW'(SW - 1 - i);
        end
    end
`else
    always_comb begin
        if (r_s1_m1[SW-1])      w_lzc = SHW'(0);
        else if (r_s1_m1[SW-2]) w_lzc = SHW'(1);
        else if (r_s1_m1[SW-3]) w_lzc = SHW'(2);
        else                    w_lzc = SHW'(3);
    end
`endif

    logic [EW-1:0]  w_s2_exp;
    logic [SHW-1:0] w_s2_shamt;
    logic           w_s2_right, w_s2_under, w_s2_flush;
    int             w_e1_i, w_lzc_i;

    // A normal-path E1 of 0 has no room to left-shift, so it joins the right-shift path.
    always_comb begin
        w_e1_i     = int'(r_s1_e1);
        w_lzc_i    = int'(w_lzc);
        w_s2_exp   = '0;
        w_s2_shamt = '0;
        w_s2_right = 1'b0;
        w_s2_under = 1'b0;
        w_s2_flush = 1'b0;
        if (r_s1_inf) begin
            w_s2_exp = r_s1_e1[EW-1:0];
        end else if (r_s1_ovf) begin
            w_s2_exp = '1;
        end else if (r_s1_m1 == '0) begin
            w_s2_exp = '0;
        end else if (r_s1_under || (w_e1_i < 1)) begin
`ifdef FP_NORM_DENORMALS_EN
            w_s2_right = 1'b1;
            w_s2_shamt = SHW'(((1 - w_e1_i) > SW) ? SW : (1 - w_e1_i));
            w_s2_under = 1'b1;
`else
            w_s2_flush = 1'b1;
            w_s2_under = 1'b1;
`endif
        end else begin
`ifdef FP_NORM_DENORMALS_EN
            if (w_lzc_i < w_e1_i) begin
                w_s2_shamt = SHW'(w_lzc_i);
                w_s2_exp   = EW'(w_e1_i - w_lzc_i);
            end else begin
                w_s2_shamt = SHW'(w_e1_i - 1);
                w_s2_under = 1'b1;
            end
`else
            if ((w_lzc_i > 2) || (w_lzc_i >= w_e1_i)) begin
                w_s2_flush = 1'b1;
                w_s2_under = 1'b1;
            end else begin
                w_s2_shamt = SHW'(w_lzc_i);
                w_s2_exp   = EW'(w_e1_i - w_lzc_i);
            end
`endif
        end
    end

    logic           r_s2_sign, r_s2_right, r_s2_under, r_s2_flush, r_s2_ovf;
    logic [EW-1:0]  r_s2_exp;
    logic [SW-1:0]  r_s2_m1;
    logic [SHW-1:0] r_s2_shamt;

    // ---------------- S3: shift ----------------
    logic          w_lost;
    logic [SW-1:0] w_shr;
    logic [SW-1:0] w_sig;
    logic          w_inexact;

    always_comb begin
        w_lost = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (i < int'(r_s2_shamt)) w_lost = w_lost | r_s2_m1[i];
        end
        w_shr = r_s2_m1 >> r_s2_shamt;
        if (r_s2_flush || r_s2_ovf)
            w_sig = '0;
        else if (r_s2_right)
            w_sig = {w_shr[SW-1:1], w_shr[0] | w_lost};
        else
            w_sig = r_s2_m1 << r_s2_shamt;
    end

    assign w_inexact = r_s2_flush ? (|r_s2_m1) : (|w_sig[2:0]);

    logic          r_o_sign, r_o_under, r_o_inexact, r_o_ovf;
    logic [EW-1:0] r_o_exp;
    logic [SW-1:0] r_o_sig;

    assign bus.o_sign     = r_o_sign;
    assign bus.o_exp      = r_o_exp;
    assign bus.o_sig      = r_o_sig;
    assign bus.under_o    = r_o_under;
    assign bus.inexact_o  = r_o_inexact;
    assign bus.overflow_o = r_o_ovf;

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_s1_sign <= 1'b0; r_s1_inf <= 1'b0; r_s1_ovf <= 1'b0; r_s1_under <= 1'b0;
            r_s1_e1 <= '0; r_s1_m1 <= '0;
            r_s2_sign <= 1'b0; r_s2_right <= 1'b0; r_s2_under <= 1'b0;
            r_s2_flush <= 1'b0; r_s2_ovf <= 1'b0;
            r_s2_exp <= '0; r_s2_m1 <= '0; r_s2_shamt <= '0;
            r_o_sign <= 1'b0; r_o_under <= 1'b0; r_o_inexact <= 1'b0; r_o_ovf <= 1'b0;
            r_o_exp <= '0; r_o_sig <= '0;
        end else begin
            if (w_ld1) begin
                r_v1 <= bus.i_valid;
                if (bus.i_valid) begin
                    r_s1_sign  <= bus.i_sign;
                    r_s1_inf   <= w_inf;
                    r_s1_ovf   <= w_ovf;
                    r_s1_under <= w_under;
                    r_s1_e1    <= w_e1;
                    r_s1_m1    <= w_m1;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2_sign  <= r_s1_sign;
                    r_s2_right <= w_s2_right;
                    r_s2_under <= w_s2_under;
                    r_s2_flush <= w_s2_flush;
                    r_s2_ovf   <= r_s1_ovf;
                    r_s2_exp   <= w_s2_exp;
                    r_s2_m1    <= r_s1_m1;
                    r_s2_shamt <= w_s2_shamt;
                end
            end
            if (w_ld3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_o_sign    <= r_s2_sign;
                    r_o_exp     <= r_s2_exp;
                    r_o_sig     <= w_sig;
                    r_o_under   <= r_s2_under;
                    r_o_inexact <= w_inexact;
                    r_o_ovf     <= r_s2_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe: per-vector results and latency, backpressure, mid-stream reset.
// Expected values follow the build's FP_NORM_DENORMALS_EN setting.
module tb_fp_normalize_pipe;
    localparam int EW = 5;
    localparam int FW = 10;
    localparam int MW = 24;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    int   checks   = 0;
    int   failures = 0;

    fp_normalize_pipe_if #(.EW(EW), .FW(FW), .MW(MW)) bus ();

    fp_normalize_pipe #(.EW(EW), .FW(FW), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [4:0]  e;
        logic [23:0] m;
        logic        u;
        logic [4:0]  xe;
        logic [13:0] xs;
        logic        xu;
        logic        xi;
        logic        xo;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.i_sign  = v.sgn;
        bus.i_exp   = v.e;
        bus.i_man   = v.m;
        bus.under_i = v.u;
    endtask

    task automatic check_out(input string pfx, input vec_t v);
        chk($sformatf("%s_sign", pfx),    bus.o_sign,     v.sgn);
        chk($sformatf("%s_exp", pfx),     bus.o_exp,      v.xe);
        chk($sformatf("%s_sig", pfx),     bus.o_sig,      v.xs);
        chk($sformatf("%s_under", pfx),   bus.under_o,    v.xu);
        chk($sformatf("%s_inexact", pfx), bus.inexact_o,  v.xi);
        chk($sformatf("%s_ovf", pfx),     bus.overflow_o, v.xo);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   n;
        v = vecs[idx];
        drive(v);
        bus.i_valid = 1'b1;
        bus.o_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_iready", idx), bus.i_ready, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
            bus.i_valid = 1'b0;
        end while (!bus.o_valid && n < 10);
        chk($sformatf("v%0d_latency", idx), n, 3);
        check_out($sformatf("v%0d", idx), v);
        tick();
    endtask

    initial begin
        int order [5];
        int sent;
        int got;
        int seen;

        // sgn, i_exp, i_man, under_i | o_exp, o_sig, under_o, inexact_o, overflow_o
        vecs[0]  = '{1'b0, 5'd15, 24'h400000, 1'b0, 5'd16, 14'h2000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd30, 24'h800000, 1'b0, 5'd31, 14'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd20, 24'h800001, 1'b0, 5'd22, 14'h2001, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd12, 24'h000000, 1'b0, 5'd0,  14'h0000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd31, 24'h200000, 1'b0, 5'd31, 14'h2000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd7,  24'h2ABC00, 1'b0, 5'd7,  14'h2ABC, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd29, 24'h400000, 1'b0, 5'd30, 14'h2000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd30, 24'h400000, 1'b0, 5'd31, 14'h0000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'd31, 24'h800000, 1'b1, 5'd1,  14'h2000, 1'b0, 1'b0, 1'b0};
`ifdef FP_NORM_DENORMALS_EN
        vecs[2]  = '{1'b0, 5'd10, 24'h020000, 1'b0, 5'd6,  14'h2000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd29, 24'h200000, 1'b1, 5'd0,  14'h0200, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd3,  24'h020000, 1'b0, 5'd0,  14'h0800, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd16, 24'h200000, 1'b1, 5'd0,  14'h0001, 1'b1, 1'b1, 1'b0};
`else
        vecs[2]  = '{1'b0, 5'd10, 24'h020000, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd29, 24'h200000, 1'b1, 5'd0,  14'h0000, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd3,  24'h020000, 1'b0, 5'd0,  14'h0000, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 5'd16, 24'h200000, 1'b1, 5'd0,  14'h0000, 1'b1, 1'b1, 1'b0};
`endif

        // Reset state
        ce          = 1'b1;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        drive(vecs[5]);
        tick();
        tick();
        chk("rst_ovalid",  bus.o_valid,    1'b0);
        chk("rst_sign",    bus.o_sign,     1'b0);
        chk("rst_exp",     bus.o_exp,      5'd0);
        chk("rst_sig",     bus.o_sig,      14'd0);
        chk("rst_under",   bus.under_o,    1'b0);
        chk("rst_inexact", bus.inexact_o,  1'b0);
        chk("rst_ovf",     bus.overflow_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_iready", bus.i_ready, 1'b1);
        tick();

        // Directed vectors, one at a time
        for (int k = 0; k < 13; k++) run_vec(k);

        // Clock enable low: nothing accepted, nothing advances
        ce = 1'b0;
        drive(vecs[0]);
        bus.i_valid = 1'b1;
        #1;
        chk("ce_low_iready", bus.i_ready, 1'b0);
        tick();
        tick();
        bus.i_valid = 1'b0;
        ce = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.o_valid) seen++;
            tick();
        end
        chk("ce_low_no_beat", seen, 0);

        // Backpressure: 5 back-to-back beats, downstream stalled in cycles 2..4
        order = '{0, 4, 7, 9, 2};
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            bus.o_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 5) begin
                drive(vecs[order[sent]]);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (cyc == 2) chk("bp_iready_two_held", bus.i_ready, 1'b1);
            if (cyc == 3) begin
                chk("bp_iready_full", bus.i_ready, 1'b0);
                chk("bp_stall_valid", bus.o_valid, 1'b1);
            end
            if (cyc == 4) begin
                chk("bp_hold_exp", bus.o_exp, vecs[order[0]].xe);
                chk("bp_hold_sig", bus.o_sig, vecs[order[0]].xs);
            end
            if (bus.o_valid && bus.o_ready) begin
                check_out($sformatf("bp%0d", got), vecs[order[got]]);
                got++;
            end
            if (bus.i_valid && bus.i_ready) sent++;
            tick();
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        chk("bp_sent", sent, 5);
        chk("bp_received", got, 5);
        tick();

        // Reset with two beats in flight
        drive(vecs[4]);
        bus.i_valid = 1'b1;
        tick();
        drive(vecs[7]);
        tick();
        bus.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ovalid",  bus.o_valid,    1'b0);
        chk("mrst_sign",    bus.o_sign,     1'b0);
        chk("mrst_exp",     bus.o_exp,      5'd0);
        chk("mrst_sig",     bus.o_sig,      14'd0);
        chk("mrst_under",   bus.under_o,    1'b0);
        chk("mrst_inexact", bus.inexact_o,  1'b0);
        chk("mrst_ovf",     bus.overflow_o, 1'b0);
        chk("mrst_iready",  bus.i_ready,    1'b1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.o_valid) seen++;
            tick();
        end
        chk("mrst_no_ghost", seen, 0);

        // Pipe still works after the mid-stream reset
        run_vec(9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_normalize_pipe.md
# fp_normalize_pipe

Parametrised, handshaked floating-point normalization pipeline. It generalises the fixed-width normalizer to any exponent and fraction width, with valid/ready flow control and an explicit overflow flag. It sits between the add/mul/fma datapaths, which produce three-whole-digit intermediates, and the rounding unit.

## Interface
- EW, 5: exponent width.
- FW, 10: fraction width, excluding the hidden bit.
- MW, 24: input mantissa width. The top 3 bits are whole digits. MW >= FW+7.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- ce  in  1  clock enable. When low, no stage advances and i_ready=0.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid&i_ready.
- i_sign  in  1  sign.
- i_exp  in  EW  biased exponent. Two's-complement signed when under_i=1.
- i_man  in  MW  mantissa, 3 whole bits.
- under_i  in  1  exponent underflowed (negative).
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts when o_valid&o_ready.
- o_sign  out  1  sign, passed through unchanged.
- o_exp  out  EW  normalized exponent.
- o_sig  out  FW+4  {hidden, FW fraction, G, R, S}.
- under_o  out  1  result is denormal or flushed.
- inexact_o  out  1  OR of o_sig[2:0].
- overflow_o  out  1  exponent increment reached infinity.

## Operation
- **S1 (increment):** inf = &i_exp & !under_i.
  - inc = 0 if inf; else 2 if i_man[MW-1]; else 1 if i_man[MW-2]; else 0.
  - E1 = i_exp + inc. E1 is EW+1 bits, signed if under_i.
  - Alignment index t = MW-3+inc.
  - m1 = {i_man[t -: FW+3], |i_man[t-FW-3:0]}.
  - If !under_i, !inf and E1 >= 2^EW-1: overflow. Force o_exp all-ones, o_sig 0, overflow_o=1.
  - If under_i and E1 >= 1: treat the beat as normal and clear the underflow.
- **S2 (count):** lzc = leading zeros of m1, range 0..FW+4.
  - Normal path:
    - lzc < E1: lshift = lzc, exp = E1-lzc.
    - Otherwise: lshift = E1-1, exp = 0, under_o=1.
  - Underflow path: rshift = min(1-E1, FW+4), exp = 0, under_o=1.
  - inf (NaN/Inf): no shift, exponent and mantissa unchanged.
  - m1 = 0: exp 0, sig 0, under_o=0.
- **S3 (shift):**
  - Left shift fills with zeros. The S bit shifts as an ordinary bit.
  - Right shift ORs all shifted-out bits into o_sig[0].
  - Result is registered into the output stage.

## Timing
- Three register stages, each holding a valid bit: v1, v2, v3 (v3 = o_valid).
- Stage k advances when ce & (!v(k+1) | adv(k+1)). adv3 = ce & o_ready.
- i_ready = ce & (!v1 | adv1). It is combinational from o_ready through the chain.
- Latency: 3 cycles from acceptance to o_valid with no backpressure. Throughput 1 beat per clock.
- Capacity is 3 beats. Order is preserved, with no drop and no duplicate.
- While o_valid&!o_ready, all output fields hold stable.
- Reset values: v1..v3=0, o_valid=0, o_sign=0, o_exp=0, o_sig=0, under_o=0, inexact_o=0, overflow_o=0.
- Reset mid-operation discards all in-flight beats. i_ready=ce in the next cycle.
- Reset has priority over ce.
- A beat is accepted in the same cycle a beat leaves when the pipe is full and o_ready=1.

## Configuration
- FP_NORM_DENORMALS_EN defined:
  - Full LZC over FW+4 bits.
  - Underflow right-shift path and gradual denormals as described in Operation.
- FP_NORM_DENORMALS_EN undefined:
  - LZC only resolves 0, 1 or 2.
  - Flush to zero when lzc > 2 (nonzero m1), or under_i survives S1, or the normal path would produce exp 0.
  - Flush result: o_exp 0, o_sig 0, under_o=1, inexact_o = |m1.
  - Latency and handshake are unchanged.

## Test plan
All scenarios use defaults EW=5, FW=10, MW=24.
- **Increment by one:** i_exp=15, i_man=24'h400000. Response after 3 cycles: o_exp=16, o_sig=14'h2000, flags 0.
- **Overflow:** i_exp=30, i_man=24'h800000. Response: o_exp=31, o_sig=0, overflow_o=1, under_o=0.
- **Left shift:** i_exp=10, i_man=24'h020000.
  - Macro defined: o_exp=6, o_sig=14'h2000.
  - Macro undefined: o_exp=0, o_sig=0, under_o=1, inexact_o=1.
- **Underflow right shift (macro defined):** under_i=1, i_exp=5'b11101, i_man=24'h200000. Response: o_exp=0, o_sig=14'h0200, under_o=1, inexact_o=0.
- **Backpressure:** 5 back-to-back beats, o_ready=0 for cycles 2-4.
  - i_ready drops once 3 beats are held.
  - All 5 emerge in order with values matching the unstalled run.
- **Reset mid-stream:** rst pulsed with 2 beats in flight. Next cycle: o_valid=0, all outputs 0, i_ready=1. The in-flight beats never appear.
